// File: rtl/raster_zfetch.sv
// Z-fetch ahead of the Z-test/write stage with clear sequencing; RASTER_ZFETCH_STATS_EN adds counters.
// Latency RD_LAT+2, 1 frag/cycle; frag_ready drops on same-pixel hazard, clear_start, drain or clear.
module raster_zfetch #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frag_valid,
  output logic              frag_ready,
  input  logic [9:0]        frag_x,
  input  logic [8:0]        frag_y,
  input  logic [17:0]       frag_z,
  input  logic [15:0]       frag_color,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              zrd_en,
  output logic [ADDR_W-1:0] zrd_addr,
  input  logic [17:0]       zrd_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [17:0]       pixelZ,
  output logic [17:0]       currZ,
  output logic [15:0]       color_out,
  output logic              rasterPixel,
  output logic              clearPixel,
  output logic [31:0]       stat_frags,
  output logic [31:0]       stat_stalls
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [17:0]       z;
    logic [15:0]       color;
  } entry_t;

  // pipe[0] is the issue stage, pipe[1..RD_LAT] wait for read data
  entry_t pipe [RD_LAT+1];

  logic [1:0]        state;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] fragAddr;
  logic              hazard;
  logic              pipeBusy;
  logic              accept;

  always_comb begin
    fragAddr = ADDR_W'(frag_y) * ADDR_W'(SCREEN_W) + ADDR_W'(frag_x);
  end

  // The output stage counts too: the end stage writes during that cycle.
  always_comb begin
    hazard   = rasterPixel && (pix_addr == fragAddr);
    pipeBusy = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) begin
      if (pipe[k].vld) begin
        pipeBusy = 1'b1;
        if (pipe[k].addr == fragAddr) hazard = 1'b1;
      end
    end
  end

  assign frag_ready = (state == RUN) & ~clear_start & ~hazard;
  assign accept     = frag_valid & frag_ready;
  assign zrd_en     = pipe[0].vld;
  assign zrd_addr   = pipe[0].addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= RD_LAT; k++) pipe[k] <= '0;
    end else begin
      if (accept) pipe[0] <= '{vld: 1'b1, addr: fragAddr, z: frag_z, color: frag_color};
      else        pipe[0] <= '0;
      for (int k = 1; k <= RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      clrCnt      <= '0;
      clear_busy  <= 1'b0;
      rasterPixel <= 1'b0;
      clearPixel  <= 1'b0;
      pix_addr    <= '0;
      pixelZ      <= '0;
      currZ       <= '0;
      color_out   <= '0;
    end else begin
      rasterPixel <= pipe[RD_LAT].vld;
      clearPixel  <= 1'b0;
      if (pipe[RD_LAT].vld) begin
        pix_addr  <= pipe[RD_LAT].addr;
        pixelZ    <= pipe[RD_LAT].z;
        currZ     <= zrd_data;
        color_out <= pipe[RD_LAT].color;
      end else begin
        pix_addr  <= '0;
        pixelZ    <= '0;
        currZ     <= '0;
        color_out <= '0;
      end

      case (state)
        RUN: begin
          if (clear_start) begin
            state      <= DRAIN;
            clear_busy <= 1'b1;
          end
        end
        DRAIN: begin
          // Start sweeping only once the last fragment has left the output stage.
          if (!pipeBusy && !rasterPixel) begin
            state      <= CLEAR;
            clrCnt     <= '0;
            clearPixel <= 1'b1;
            pix_addr   <= '0;
          end
        end
        CLEAR: begin
          if (clrCnt == CLR_LAST) begin
            state      <= RUN;
            clear_busy <= 1'b0;
          end else begin
            clrCnt     <= clrCnt + ADDR_W'(1);
            clearPixel <= 1'b1;
            pix_addr   <= clrCnt + ADDR_W'(1);
          end
        end
        default: begin
          state      <= RUN;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef RASTER_ZFETCH_STATS_EN
  logic [31:0] statFrags;
  logic [31:0] statStalls;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      statFrags  <= '0;
      statStalls <= '0;
    end else begin
      if (accept && statFrags != 32'hFFFF_FFFF) statFrags <= statFrags + 32'd1;
      if (frag_valid && hazard && statStalls != 32'hFFFF_FFFF) statStalls <= statStalls + 32'd1;
    end
  end

  assign stat_frags  = statFrags;
  assign stat_stalls = statStalls;
`else
  assign stat_frags  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_raster_zfetch.sv
// Scoreboard bench for raster_zfetch with a behavioural Z-buffer answering reads RD_LAT cycles later.
module tb_raster_zfetch;
  localparam int TW  = 640;
  localparam int TH  = 8;
  localparam int AW  = 19;
  localparam int RDL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frag_valid;
  logic          frag_ready;
  logic [9:0]    frag_x;
  logic [8:0]    frag_y;
  logic [17:0]   frag_z;
  logic [15:0]   frag_color;
  logic          clear_start;
  logic          clear_busy;
  logic          zrd_en;
  logic [AW-1:0] zrd_addr;
  logic [17:0]   zrd_data;
  logic [AW-1:0] pix_addr;
  logic [17:0]   pixelZ;
  logic [17:0]   currZ;
  logic [15:0]   color_out;
  logic          rasterPixel;
  logic          clearPixel;
  logic [31:0]   stat_frags;
  logic [31:0]   stat_stalls;

  raster_zfetch #(.SCREEN_W(TW), .SCREEN_H(TH), .ADDR_W(AW), .RD_LAT(RDL)) dut (
    .clk(clk), .reset_n(reset_n),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z), .frag_color(frag_color),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .zrd_en(zrd_en), .zrd_addr(zrd_addr), .zrd_data(zrd_data),
    .pix_addr(pix_addr), .pixelZ(pixelZ), .currZ(currZ), .color_out(color_out),
    .rasterPixel(rasterPixel), .clearPixel(clearPixel),
    .stat_frags(stat_frags), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [17:0]   z;
    logic [17:0]   cz;
    logic [15:0]   col;
  } exp_t;

  exp_t sbq[$];
  exp_t zq[$];
  exp_t monE;
  int   nVec = 0;
  int   nMis = 0;
  int   cyc = 0;
  int   runLen = 0;
  int   maxRun = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] zMem(input logic [AW-1:0] a);
    if (a == AW'(1283)) return 18'h10000;
    return a[17:0] ^ 18'h2A5A5;
  endfunction

  always @(posedge clk) cyc++;

  // Z-buffer: data for a read seen in cycle c is on the bus during cycle c+RDL
  logic [17:0] hd [RDL+1];
  bit          hv [RDL+1];
  initial begin
    for (int i = 0; i <= RDL; i++) begin hv[i] = 1'b0; hd[i] = '0; end
    zrd_data = 18'h3ABCD;
    forever begin
      @(posedge clk);
      #1;
      for (int i = RDL; i > 0; i--) begin hd[i] = hd[i-1]; hv[i] = hv[i-1]; end
      hv[0] = reset_n && zrd_en;
      hd[0] = zMem(zrd_addr);
      zrd_data = hv[RDL] ? hd[RDL] : 18'h3ABCD;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (rasterPixel) begin
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if (clearPixel) checkEq("rasterInClear", rasterPixel, 0);
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        monE = sbq.pop_front();
        checkEq("outMissing", cyc, monE.due);
      end
      if (rasterPixel) begin
        if (sbq.size() == 0) checkEq("spurRaster", rasterPixel, 0);
        else begin
          monE = sbq.pop_front();
          checkEq("outCycle", cyc, monE.due);
          checkEq("pix_addr", pix_addr, monE.addr);
          checkEq("pixelZ", pixelZ, monE.z);
          checkEq("currZ", currZ, monE.cz);
          checkEq("color_out", color_out, monE.col);
        end
      end
      while (zq.size() > 0 && zq[0].due < cyc) begin
        monE = zq.pop_front();
        checkEq("readMissing", cyc, monE.due);
      end
      if (zrd_en) begin
        if (zq.size() == 0) checkEq("spurRead", zrd_en, 0);
        else begin
          monE = zq.pop_front();
          checkEq("rdCycle", cyc, monE.due);
          checkEq("zrd_addr", zrd_addr, monE.addr);
        end
      end
    end
  end

  task automatic sendFrag(input int x, input int y, input logic [17:0] z, input logic [15:0] c,
                          output int waited);
    exp_t e;
    frag_valid = 1'b1;
    frag_x = 10'(x);
    frag_y = 9'(y);
    frag_z = z;
    frag_color = c;
    waited = 0;
    forever begin
      @(negedge clk);
      if (frag_ready) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) checkEq("acceptTimeout", waited, 0);
    else begin
      e.addr = AW'(y * TW + x);
      e.z    = z;
      e.cz   = zMem(e.addr);
      e.col  = c;
      e.due  = cyc + 1;
      zq.push_back(e);
      e.due  = cyc + RDL + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    frag_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && (sbq.size() > 0 || zq.size() > 0); i++) @(negedge clk);
    checkEq("drained", sbq.size() + zq.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic chkZero(input string tag);
    checkEq({tag, "_raster"}, rasterPixel, 0);
    checkEq({tag, "_clear"}, clearPixel, 0);
    checkEq({tag, "_busy"}, clear_busy, 0);
    checkEq({tag, "_zrd_en"}, zrd_en, 0);
    checkEq({tag, "_zrd_addr"}, zrd_addr, 0);
    checkEq({tag, "_pix_addr"}, pix_addr, 0);
    checkEq({tag, "_pixelZ"}, pixelZ, 0);
    checkEq({tag, "_currZ"}, currZ, 0);
    checkEq({tag, "_color"}, color_out, 0);
    checkEq({tag, "_statFrags"}, stat_frags, 0);
    checkEq({tag, "_statStalls"}, stat_stalls, 0);
    checkEq({tag, "_ready"}, frag_ready, 1);
  endtask

  // Called the cycle after clear_start was sampled.
  task automatic runClear(input int expRaster, input string tag);
    int clrN = 0;
    int clrErr = 0;
    int rasterBefore = 0;
    @(negedge clk);
    checkEq({tag, "_busyAfterStart"}, clear_busy, 1);
    for (int i = 0; i < TW * TH + 200; i++) begin
      if (clearPixel) begin
        if (pix_addr != AW'(clrN)) clrErr++;
        if (pixelZ != 0 || currZ != 0 || color_out != 0 || zrd_en) clrErr++;
        if (!clear_busy) clrErr++;
        clrN++;
      end else if (clrN > 0) begin
        checkEq({tag, "_busyFall"}, clear_busy, 0);
        checkEq({tag, "_readyAfter"}, frag_ready, 1);
        break;
      end else if (rasterPixel) begin
        rasterBefore++;
      end
      @(negedge clk);
    end
    checkEq({tag, "_rasterBefore"}, rasterBefore, expRaster);
    checkEq({tag, "_clrCount"}, clrN, TW * TH);
    checkEq({tag, "_clrErrs"}, clrErr, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int found;
    int cp;
    int bs;
    int rdyLow;
    logic [31:0] expFrags;
    logic [31:0] expStalls;
    reset_n = 1'b0;
    frag_valid = 1'b0;
    frag_x = '0;
    frag_y = '0;
    frag_z = '0;
    frag_color = '0;
    clear_start = 1'b0;
    repeat (2) @(negedge clk);
    chkZero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single fragment with explicit per-cycle timing
    sendFrag(3, 2, 18'h1F000, 16'hF800, w);
    checkEq("singleWait", w, 0);
    @(negedge clk);
    checkEq("t1_zrd_en", zrd_en, 1);
    checkEq("t1_zrd_addr", zrd_addr, 1283);
    repeat (2) begin
      @(negedge clk);
      checkEq("earlyRaster", rasterPixel, 0);
    end
    @(negedge clk);
    checkEq("t4_raster", rasterPixel, 1);
    checkEq("t4_pix_addr", pix_addr, 1283);
    checkEq("t4_pixelZ", pixelZ, 18'h1F000);
    checkEq("t4_currZ", currZ, 18'h10000);
    checkEq("t4_color", color_out, 16'hF800);
    @(negedge clk);
    checkEq("t5_raster", rasterPixel, 0);
    waitDrain();

    // back-to-back distinct addresses
    maxRun = 0;
    for (int i = 0; i < 8; i++) begin
      sendFrag(10 + i * 3, 7, 18'($urandom), 16'($urandom), w);
      checkEq("b2bWait", w, 0);
    end
    waitDrain();
    checkEq("b2bRun", maxRun, 8);

    // same-pixel hazard
    sendFrag(5, 5, 18'h00123, 16'h07E0, w);
    sendFrag(5, 5, 18'h00456, 16'h001F, w);
    checkEq("hazWait", w, 4);
    waitDrain();
`ifdef RASTER_ZFETCH_STATS_EN
    expStalls = 32'd4;
    expFrags  = 32'd11;
`else
    expStalls = 32'd0;
    expFrags  = 32'd0;
`endif
    checkEq("statStalls", stat_stalls, expStalls);
    checkEq("statFrags", stat_frags, expFrags);

    // clear with three fragments in flight
    sendFrag(20, 1, 18'h0AAAA, 16'h1234, w);
    sendFrag(21, 1, 18'h15555, 16'h5678, w);
    sendFrag(22, 1, 18'h3FFFF, 16'h9ABC, w);
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    runClear(3, "clr3");

    // clear_start wins over a coincident fragment
    frag_valid = 1'b1;
    frag_x = 10'd100;
    frag_y = 9'd1;
    clear_start = 1'b1;
    @(negedge clk);
    checkEq("coincReady", frag_ready, 0);
    @(posedge clk);
    #1;
    frag_valid = 1'b0;
    clear_start = 1'b0;
    runClear(0, "coinc");

    // reset in the middle of a clear sweep
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    found = 0;
    for (int i = 0; i < TW * TH + 50 && found == 0; i++) begin
      @(negedge clk);
      if (clearPixel && pix_addr == AW'(1000)) found = 1;
    end
    checkEq("rstAt1000", found, 1);
    reset_n = 1'b0;
    #1;
    chkZero("midClr");
    @(negedge clk);
    reset_n = 1'b1;
    cp = 0;
    bs = 0;
    rdyLow = 0;
    repeat (20) begin
      @(negedge clk);
      cp += int'(clearPixel);
      bs += int'(clear_busy);
      rdyLow += int'(!frag_ready);
    end
    checkEq("postRstClear", cp, 0);
    checkEq("postRstBusy", bs, 0);
    checkEq("postRstReadyLow", rdyLow, 0);
    @(posedge clk);
    #1;
    sendFrag(7, 3, 18'h2468A, 16'hBEEF, w);
    checkEq("postRstWait", w, 0);
    waitDrain();

    checkEq("sbEmpty", sbq.size() + zq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
